// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the registered full adder
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder with registered sum, carry-out and signed overflow
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  full_adder_if.slave bus
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
    assign c[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
  end

  // Result registers only load on accepted operands so they hold across idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum      <= s;
        bus.cout     <= c[WIDTH];
        bus.overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed scoreboard bench for 1-bit and 8-bit full_adder instances
module tb_full_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t q1[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer addition, overflow from operand/result sign bits
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    logic [7:0] mask;
    exp_t e;
    mask   = 8'((9'd1 << w) - 9'd1);
    full   = {1'b0, a & mask} + {1'b0, b & mask} + {8'd0, cin};
    e.sum  = full[7:0] & mask;
    e.cout = full[w];
    e.ov   = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic step1(input string tag, input logic a, input logic b, input logic cin, input logic v);
    exp_t e;
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.in_valid = v;
    if (v) q1.push_back(model(1, {7'd0, a}, {7'd0, b}, cin));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 64'(bus1.out_valid), 64'(v));
    if (bus1.out_valid && q1.size() > 0) begin
      e = q1.pop_front();
      chk({tag, ".sum"},      64'(bus1.sum),      64'(e.sum[0]));
      chk({tag, ".cout"},     64'(bus1.cout),     64'(e.cout));
      chk({tag, ".overflow"}, 64'(bus1.overflow), 64'(e.ov));
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin);
    exp_t e;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.in_valid = 1'b1;
    q8.push_back(model(8, a, b, cin));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 64'(bus8.out_valid), 64'd1);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk({tag, ".sum"},      64'(bus8.sum),      64'(e.sum));
      chk({tag, ".cout"},     64'(bus8.cout),     64'(e.cout));
      chk({tag, ".overflow"}, 64'(bus8.overflow), 64'(e.ov));
    end
    bus8.in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] tt_sum;
    logic [3:0] tt_cout;
    logic [7:0] tt_s;
    logic [7:0] tt_c;
    logic [2:0] idx;

    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;

    // Reset state
    #2;
    chk("rst1.sum",       64'(bus1.sum),       64'd0);
    chk("rst1.cout",      64'(bus1.cout),      64'd0);
    chk("rst1.out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst8.sum",       64'(bus8.sum),       64'd0);
    chk("rst8.overflow",  64'(bus8.overflow),  64'd0);
    chk("rst8.out_valid", 64'(bus8.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Exhaustive 1-bit sweep against a literal truth table (index = {a,b,cin})
    tt_s = 8'b1001_0110;
    tt_c = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      bus1.a = idx[2]; bus1.b = idx[1]; bus1.cin = idx[0]; bus1.in_valid = 1'b1;
      q1.push_back(model(1, {7'd0, idx[2]}, {7'd0, idx[1]}, idx[0]));
      @(posedge clk); #1;
      chk($sformatf("tt%0d.out_valid", i), 64'(bus1.out_valid), 64'd1);
      chk($sformatf("tt%0d.sum", i),  64'(bus1.sum),  64'(tt_s[idx]));
      chk($sformatf("tt%0d.cout", i), 64'(bus1.cout), 64'(tt_c[idx]));
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk($sformatf("tt%0d.overflow", i), 64'(bus1.overflow), 64'(e.ov));
      end
    end
    bus1.in_valid = 1'b0;
    tt_sum = '0; tt_cout = '0;

    // 1-bit overflow corners
    step1("ov110", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ov110.overflow_lit", 64'(bus1.overflow), 64'd1);
    step1("ov111", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("ov111.overflow_lit", 64'(bus1.overflow), 64'd0);

    // 8-bit carry wrap, signed overflow, carry-in path
    step8("w_ff01", 8'hFF, 8'h01, 1'b0);
    chk("w_ff01.sum_lit", 64'(bus8.sum), 64'h00);
    step8("w_7f01", 8'h7F, 8'h01, 1'b0);
    chk("w_7f01.sum_lit", 64'(bus8.sum), 64'h80);
    chk("w_7f01.ov_lit",  64'(bus8.overflow), 64'd1);
    step8("w_0000c", 8'h00, 8'h00, 1'b1);
    chk("w_0000c.sum_lit", 64'(bus8.sum), 64'h01);
    step8("w_ffffc", 8'hFF, 8'hFF, 1'b1);
    chk("w_ffffc.sum_lit",  64'(bus8.sum),  64'hFF);
    chk("w_ffffc.cout_lit", 64'(bus8.cout), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Hold: idle cycles with changing operands must not disturb the result
    step8("hold_cap", 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      bus8.in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("hold%0d.out_valid", i), 64'(bus8.out_valid), 64'd0);
      chk($sformatf("hold%0d.sum", i),       64'(bus8.sum),       64'h46);
      chk($sformatf("hold%0d.cout", i),      64'(bus8.cout),      64'd0);
    end

    // Asynchronous reset mid-stream, then first post-reset operands
    step1("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1);
    bus1.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.sum",       64'(bus1.sum),       64'd0);
    chk("arst.cout",      64'(bus1.cout),      64'd0);
    chk("arst.overflow",  64'(bus1.overflow),  64'd0);
    chk("arst.out_valid", 64'(bus1.out_valid), 64'd0);
    q1.delete();
    #1 rst = 1'b0;
    step1("post_rst", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("post_rst.sum_lit",  64'(bus1.sum),  64'd0);
    chk("post_rst.cout_lit", 64'(bus1.cout), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
